// File: rtl/lcd_bus_decoder.sv
// Receive side of a 4-bit HD44780-style LCD bus: synchronises E/RS/RW/DAT, decodes
// nibble pairs into commands and data, and keeps a 32-cell shadow of the screen.
module lcd_bus_decoder #(
   parameter int          SYNC_STAGES = 2,
   parameter logic [7:0]  FILL_CHAR   = 8'h20
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         lcd_e,
   input  logic         lcd_rs,
   input  logic         lcd_rw,
   input  logic [3:0]   lcd_dat,
   input  logic         err_clr,
   output logic [255:0] screen,
   output logic [4:0]   cursor,
   output logic         mode_4bit,
   output logic         display_on,
   output logic         busy,
   output logic         cmd_valid,
   output logic         data_valid,
   output logic [7:0]   byte_out,
   output logic         err_overrun,
   output logic         err_addr,
   output logic [1:0]   dbg_state
);

   typedef enum logic [1:0] {INIT8 = 2'd0, HI = 2'd1, LO = 2'd2, CLEAR = 2'd3} state_t;

   state_t      state, state_d;
   logic [6:0]  sync_q [SYNC_STAGES];
   logic        e_prev;
   logic [3:0]  upper_q;
   logic        rs_q;
   logic        inc_q;
   logic [4:0]  clr_idx;
   logic [7:0]  cells [32];

   logic        e_s, rs_s, rw_s, wr_stb;
   logic [3:0]  dat_s;
   logic [7:0]  exec_byte;
   logic [6:0]  addr;
   logic        addr_ok;
   logic [4:0]  addr_cell;

   assign e_s       = sync_q[SYNC_STAGES-1][6];
   assign rs_s      = sync_q[SYNC_STAGES-1][5];
   assign rw_s      = sync_q[SYNC_STAGES-1][4];
   assign dat_s     = sync_q[SYNC_STAGES-1][3:0];
   assign wr_stb    = e_prev & ~e_s & ~rw_s;
   assign exec_byte = {upper_q, dat_s};
   assign addr      = exec_byte[6:0];
   assign addr_ok   = (addr <= 7'h0F) || (addr >= 7'h40 && addr <= 7'h4F);
   assign addr_cell = {addr[6], addr[3:0]};
   assign busy      = (state == CLEAR);
   assign dbg_state = state;

   // One bundle through one chain keeps E aligned with RS/RW/DAT.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         e_prev <= 1'b0;
      end else begin
         sync_q[0] <= {lcd_e, lcd_rs, lcd_rw, lcd_dat};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         e_prev <= e_s;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= INIT8;
      else      state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         INIT8:   if (wr_stb && dat_s == 4'h2) state_d = HI;
         HI:      if (wr_stb) state_d = LO;
         LO:      if (wr_stb) state_d = (!rs_q && exec_byte == 8'h01) ? CLEAR : HI;
         CLEAR:   if (clr_idx == 5'd31) state_d = HI;
         default: state_d = INIT8;
      endcase
   end

   // cmd_valid/data_valid are single-cycle valid strobes with no ready: byte_out
   // carries the decoded byte during the pulse and holds it afterwards.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) cells[i] <= FILL_CHAR;
         cursor      <= '0;
         mode_4bit   <= 1'b0;
         display_on  <= 1'b0;
         inc_q       <= 1'b1;
         upper_q     <= '0;
         rs_q        <= 1'b0;
         clr_idx     <= '0;
         cmd_valid   <= 1'b0;
         data_valid  <= 1'b0;
         byte_out    <= '0;
         err_overrun <= 1'b0;
         err_addr    <= 1'b0;
      end else begin
         cmd_valid  <= 1'b0;
         data_valid <= 1'b0;
         if (err_clr) begin
            err_overrun <= 1'b0;
            err_addr    <= 1'b0;
         end
         case (state)
            INIT8: if (wr_stb && (dat_s == 4'h2 || dat_s == 4'h3)) begin
               cmd_valid <= 1'b1;
               byte_out  <= {dat_s, 4'h0};
               if (dat_s == 4'h2) mode_4bit <= 1'b1;
            end
            HI: if (wr_stb) begin
               upper_q <= dat_s;
               rs_q    <= rs_s;
            end
            LO: if (wr_stb) begin
               byte_out <= exec_byte;
               if (rs_q) begin
                  data_valid    <= 1'b1;
                  cells[cursor] <= exec_byte;
                  cursor        <= inc_q ? cursor + 5'd1 : cursor - 5'd1;
               end else begin
                  cmd_valid <= 1'b1;
                  if (exec_byte == 8'h01) begin
                     cursor  <= '0;
                     clr_idx <= '0;
                  end else if (exec_byte[7:1] == 7'b0000001) begin
                     cursor <= '0;
                  end else if (exec_byte[7:2] == 6'b000001) begin
                     inc_q <= exec_byte[1];
                  end else if (exec_byte[7:3] == 5'b00001) begin
                     display_on <= exec_byte[2];
                  end else if (exec_byte[7]) begin
                     if (addr_ok) cursor   <= addr_cell;
                     else         err_addr <= 1'b1;
                  end
               end
            end
            CLEAR: begin
               cells[clr_idx] <= FILL_CHAR;
               clr_idx        <= clr_idx + 5'd1;
               if (wr_stb) err_overrun <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      screen = '0;
      for (int i = 0; i < 32; i++) screen[255 - 8*i -: 8] = cells[i];
   end

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Bench for lcd_bus_decoder: bus-level driver, transaction-level screen model,
// per-cycle state compare, pulse scoreboard and clear-length monitor.
module tb_lcd_bus_decoder;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0, err_clr = 1'b0;
   logic [3:0]   lcd_dat = '0;
   logic [255:0] screen;
   logic [4:0]   cursor;
   logic         mode_4bit, display_on, busy, cmd_valid, data_valid;
   logic [7:0]   byte_out;
   logic         err_overrun, err_addr;
   logic [1:0]   dbg_state;

   always #5 clk = ~clk;

   lcd_bus_decoder dut (
      .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
      .lcd_dat(lcd_dat), .err_clr(err_clr), .screen(screen), .cursor(cursor),
      .mode_4bit(mode_4bit), .display_on(display_on), .busy(busy),
      .cmd_valid(cmd_valid), .data_valid(data_valid), .byte_out(byte_out),
      .err_overrun(err_overrun), .err_addr(err_addr), .dbg_state(dbg_state)
   );

   int n_pass = 0, n_total = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
   endtask

   // Model: screen contents and control state at the granularity of bus nibbles
   logic [7:0] m_scr [32];
   logic [4:0] m_cur;
   logic [3:0] m_up;
   bit         m_mode, m_disp, m_inc, m_rsl, m_clearing, m_ov, m_ea, settled;
   int         m_phase;
   logic [8:0] exp_q [$];

   function automatic logic [255:0] m_pack();
      logic [255:0] s;
      for (int i = 0; i < 32; i++) s[255 - 8*i -: 8] = m_scr[i];
      return s;
   endfunction

   function automatic logic [255:0] all_fill();
      logic [255:0] s;
      for (int i = 0; i < 32; i++) s[255 - 8*i -: 8] = 8'h20;
      return s;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_scr[i] = 8'h20;
      m_cur = 0; m_up = 0; m_mode = 0; m_disp = 0; m_inc = 1; m_rsl = 0;
      m_clearing = 0; m_ov = 0; m_ea = 0; m_phase = 0;
      exp_q.delete();
   endtask

   task automatic model_cmd(input logic [7:0] b);
      int a;
      if (b == 8'h01) begin
         for (int i = 0; i < 32; i++) m_scr[i] = 8'h20;
         m_cur = 0; m_clearing = 1;
      end else if (b == 8'h02 || b == 8'h03) m_cur = 0;
      else if (b >= 8'h04 && b < 8'h08) m_inc = b[1];
      else if (b >= 8'h08 && b < 8'h10) m_disp = b[2];
      else if (b >= 8'h80) begin
         a = int'(b) - 128;
         if (a < 16) m_cur = 5'(a);
         else if (a >= 64 && a < 80) m_cur = 5'(a - 48);
         else m_ea = 1;
      end
   endtask

   task automatic model_nib(input bit rs, input bit rw, input logic [3:0] n);
      logic [7:0] b;
      if (rw) return;
      if (m_clearing) begin m_ov = 1; return; end
      case (m_phase)
         0: if (n == 4'h2 || n == 4'h3) begin
            exp_q.push_back({1'b0, n, 4'h0});
            if (n == 4'h2) begin m_mode = 1; m_phase = 1; end
         end
         1: begin m_up = n; m_rsl = rs; m_phase = 2; end
         default: begin
            b = {m_up, n};
            m_phase = 1;
            if (m_rsl) begin
               exp_q.push_back({1'b1, b});
               m_scr[m_cur] = b;
               m_cur = m_inc ? m_cur + 5'd1 : m_cur - 5'd1;
            end else begin
               exp_q.push_back({1'b0, b});
               model_cmd(b);
            end
         end
      endcase
   endtask

   // Drivers
   task automatic send_nib(input bit rs, input bit rw, input logic [3:0] n);
      settled = 0;
      @(negedge clk);
      lcd_rs = rs; lcd_rw = rw; lcd_dat = n;
      repeat (2) @(negedge clk);
      lcd_e = 1'b1;
      repeat (4) @(negedge clk);
      model_nib(rs, rw, n);
      lcd_e = 1'b0;
      repeat (6) @(negedge clk);
      settled = !m_clearing;
   endtask

   task automatic send_byte(input bit rs, input logic [7:0] b);
      send_nib(rs, 1'b0, b[7:4]);
      send_nib(rs, 1'b0, b[3:0]);
   endtask

   task automatic wait_clear();
      repeat (40) @(negedge clk);
      m_clearing = 0;
      settled = 1;
   endtask

   task automatic clear_err();
      settled = 0;
      @(negedge clk); err_clr = 1'b1; m_ov = 0; m_ea = 0;
      @(negedge clk); err_clr = 1'b0;
      @(negedge clk); settled = 1;
   endtask

   task automatic do_init();
      send_nib(0, 0, 4'h3); send_nib(0, 0, 4'h3); send_nib(0, 0, 4'h3);
      send_nib(0, 0, 4'h2);
   endtask

   // Per-cycle state compare while the bus is quiet
   always @(negedge clk) begin
      if (rst && settled) begin
         chk("screen", screen, m_pack());
         chk("cursor", cursor, m_cur);
         chk("mode_4bit", mode_4bit, m_mode);
         chk("display_on", display_on, m_disp);
         chk("busy_idle", busy, 0);
         chk("err_overrun", err_overrun, m_ov);
         chk("err_addr", err_addr, m_ea);
      end
   end

   // Pulse scoreboard
   always @(negedge clk) begin
      logic [8:0] e;
      if (rst && (cmd_valid || data_valid)) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pulse", {data_valid, cmd_valid, byte_out}, {e[8], ~e[8], e[7:0]});
         end else chk("pulse_unexpected", {data_valid, cmd_valid, byte_out}, 10'h000);
      end
   end

   // Clear length monitor
   int bcnt = 0;
   always @(negedge clk) begin
      if (!rst) bcnt = 0;
      else if (busy) bcnt++;
      else if (bcnt != 0) begin
         chk("busy_len", bcnt, 32);
         chk("clear_fill", screen, all_fill());
         bcnt = 0;
      end
   end

   logic [255:0] str;
   logic [7:0]   rb;

   initial begin
      settled = 0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_screen", screen, all_fill());
      chk("rst_misc", {cursor, mode_4bit, display_on, busy, cmd_valid, data_valid,
                       byte_out, err_overrun, err_addr, dbg_state}, '0);
      rst = 1'b1;
      settled = 1;

      do_init();
      chk("init_mode", mode_4bit, 1'b1);
      send_byte(0, 8'h28);
      chk("init_state_hi", dbg_state, 2'd1);
      chk("init_byte", byte_out, 8'h28);

      send_byte(1, 8'h41); send_byte(1, 8'h42);
      chk("data_ab", screen[255:240], 16'h4142);
      chk("data_cursor", cursor, 5'd2);

      send_byte(0, 8'hCF); send_byte(1, 8'h5A);
      chk("cell31", screen[7:0], 8'h5A);
      chk("wrap_fwd", cursor, 5'd0);

      send_byte(0, 8'h90);
      chk("bad_addr", {err_addr, cursor}, {1'b1, 5'd0});
      clear_err();
      chk("err_clr", err_addr, 1'b0);

      send_byte(0, 8'h04); send_byte(1, 8'h33);
      chk("wrap_back", cursor, 5'd31);
      send_byte(0, 8'h06);
      send_byte(0, 8'h0C);
      chk("disp_on", display_on, 1'b1);

      // Fill with 'A', clear, and poke a strobe mid-clear
      send_byte(0, 8'h80);
      for (int i = 0; i < 32; i++) send_byte(1, 8'h41);
      send_byte(0, 8'h01);
      send_nib(1, 0, 4'h4);
      wait_clear();
      chk("overrun", err_overrun, 1'b1);
      clear_err();

      // Randomized traffic with interleaved read strobes
      for (int it = 0; it < 200; it++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: begin rb = 8'($urandom_range(0, 255)); m_rsl = 1; end
            5: rb = 8'h80 | 8'($urandom_range(0, 127));
            6: rb = 8'h04 + 8'($urandom_range(0, 3));
            7: rb = 8'h08 + 8'($urandom_range(0, 7));
            8: rb = 8'h02 + 8'($urandom_range(0, 1));
            default: rb = 8'($urandom_range(8'h10, 8'h7F));
         endcase
         begin
            bit rs;
            rs = (rb >= 8'h80 || rb < 8'h10 || $urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 1) == 1) rs = 1'b1;
            if (rb == 8'h01) rs = 1'b1;
            send_nib(rs, 0, rb[7:4]);
            if ($urandom_range(0, 3) == 0) send_nib(~rs, 1, 4'($urandom_range(0, 15)));
            send_nib(rs, 0, rb[3:0]);
         end
         if ($urandom_range(0, 15) == 0) clear_err();
      end

      // Reset in the middle of a clear
      send_byte(0, 8'h01);
      @(negedge clk); #2 rst = 1'b0;
      #1;
      chk("rst_mid_screen", screen, all_fill());
      chk("rst_mid_busy", busy, 1'b0);
      chk("rst_mid_state", dbg_state, 2'd0);
      settled = 0;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      settled = 1;

      // Full display-style bring-up and screen load
      str = "01234567 01 01  0 1 2 1         ";
      do_init();
      send_byte(0, 8'h28); send_byte(0, 8'h0C); send_byte(0, 8'h06);
      send_byte(0, 8'h01);
      wait_clear();
      send_byte(0, 8'h80);
      for (int i = 0; i < 16; i++) send_byte(1, str[255 - 8*i -: 8]);
      send_byte(0, 8'hC0);
      for (int i = 16; i < 32; i++) send_byte(1, str[255 - 8*i -: 8]);
      chk("loopback", screen, str);

      repeat (4) @(negedge clk);
      chk("pulse_queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
